// File: rtl/uart_pkg.sv
// Shared register offsets, FSM state types and constants for the MMIO UART.
// Offsets are relative to the peripheral base address.
package uart_pkg;

  localparam logic [15:0] OFF_RX0   = 16'h0000;
  localparam logic [15:0] OFF_RX1   = 16'h0004;
  localparam logic [15:0] OFF_RX2   = 16'h0008;
  localparam logic [15:0] OFF_RX3   = 16'h000C;
  localparam logic [15:0] OFF_RX4   = 16'h0010;
  localparam logic [15:0] OFF_READY = 16'h0014;
  localparam logic [15:0] OFF_TX0   = 16'h0018;
  localparam logic [15:0] OFF_TX1   = 16'h001C;
  localparam logic [15:0] OFF_TX2   = 16'h0020;
  localparam logic [15:0] OFF_TX3   = 16'h0024;
  localparam logic [15:0] OFF_FLAGS = 16'h0028;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// Byte-serial 8N1 transmitter. A start presented during the last stop-bit
// cycle chains the next frame with no idle gap.
//
// state    | meaning
// TX_IDLE  | line high, waiting for start
// TX_START | driving start bit (0)
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit (1); done on its last cycle
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;

  assign done = (state == TX_STOP) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TX_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            state <= TX_START;
            shreg <= data;
            cnt   <= FULL;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        TX_START: begin
          if (cnt == '0) begin
            state <= TX_DATA;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
            bitn  <= '0;
            cnt   <= FULL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (cnt == '0) begin
            cnt <= FULL;
            if (bitn == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
              bitn  <= bitn + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (cnt == '0) begin
            if (start) begin
              state <= TX_START;
              shreg <= data;
              cnt   <= FULL;
              tx    <= 1'b0;
            end else begin
              state <= TX_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: collects a 5-byte RX frame into word slots, and sends
// four ASCII digits from the TX slots when the last TX word is written.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to start-bit midpoint; high there means glitch
// RX_DATA  | sampling 8 data bits at full-bit spacing, LSB first
// RX_STOP  | sampling stop bit; store / overrun / frame error
module uart_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [15:0] BASE         = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [15:0] off;
  logic        rearm;

  // Addresses below BASE wrap to large offsets and fall into the default decode.
  assign off   = addr - BASE;
  assign rearm = we && (off == OFF_TX3);

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;
  logic [7:0]    rx_slot [5];
  logic [2:0]    idx;
  logic          ready, overrun, frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shreg  <= '0;
      idx       <= '0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 5; i++) rx_slot[i] <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2 && rx_s3) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= FULL;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
            rx_cnt   <= FULL;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= RX_IDLE;
            // A rearm on the same edge discards whatever this stop bit brought.
            if (!rearm) begin
              if (!rx_s2) begin
                frame_err <= 1'b1;
              end else if (ready) begin
                overrun <= 1'b1;
              end else begin
                rx_slot[idx] <= rx_shreg;
                if (idx == 3'd4) begin
                  ready <= 1'b1;
                  idx   <= 3'd5;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
      if (rearm) begin
        ready     <= 1'b0;
        idx       <= '0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
    end
  end

  logic [31:0] tx_slot [4];
  logic        go, tx_busy, tx_done, tx_start, wr_ok;
  logic [1:0]  byte_sel, next_sel;
  logic [7:0]  tx_byte;

  // go covers the one cycle between the launching write and the core going busy.
  assign wr_ok    = we && !tx_busy && !go;
  assign next_sel = go ? 2'd0 : byte_sel + 2'd1;
  assign tx_byte  = tx_slot[next_sel][7:0] + ASCII_ZERO;
  assign tx_start = go || (tx_done && (byte_sel != 2'd3));

  always_ff @(posedge clk) begin
    if (rst) begin
      go       <= 1'b0;
      byte_sel <= '0;
      for (int i = 0; i < 4; i++) tx_slot[i] <= '0;
    end else begin
      go <= 1'b0;
      if (tx_done && (byte_sel != 2'd3)) byte_sel <= byte_sel + 2'd1;
      if (wr_ok) begin
        case (off)
          OFF_TX0: tx_slot[0] <= wdata;
          OFF_TX1: tx_slot[1] <= wdata;
          OFF_TX2: tx_slot[2] <= wdata;
          OFF_TX3: begin
            tx_slot[3] <= wdata;
            go         <= 1'b1;
            byte_sel   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_byte),
    .tx    (tx),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  always_comb begin
    rdata = '0;
    case (off)
      OFF_RX0:   rdata = {24'b0, rx_slot[0]};
      OFF_RX1:   rdata = {24'b0, rx_slot[1]};
      OFF_RX2:   rdata = {24'b0, rx_slot[2]};
      OFF_RX3:   rdata = {24'b0, rx_slot[3]};
      OFF_RX4:   rdata = {24'b0, rx_slot[4]};
      OFF_READY: rdata = {31'b0, ready};
      OFF_TX0:   rdata = tx_slot[0];
      OFF_TX1:   rdata = tx_slot[1];
      OFF_TX2:   rdata = tx_slot[2];
      OFF_TX3:   rdata = tx_slot[3];
      OFF_FLAGS: rdata = {29'b0, frame_err, overrun, tx_busy};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio with a queue/array reference model of the register map,
// a serial RX driver and a serial TX decoder.
module tb_uart_mmio;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] addr = 16'h0800;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;

  uart_mmio #(.CLKS_PER_BIT(CPB), .BASE(16'h0800)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [7:0]  m_slot [5];
  logic [31:0] m_tx [4];
  bit          m_ready, m_ovr, m_ferr, m_busy;
  int          m_idx;
  logic [7:0]  exp_q [$];
  bit          mon_en = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_slot[i] = '0;
    for (int i = 0; i < 4; i++) m_tx[i] = '0;
    m_ready = 0; m_ovr = 0; m_ferr = 0; m_busy = 0; m_idx = 0;
  endtask

  task automatic model_rx(input logic [7:0] b, input bit good);
    if (!good) m_ferr = 1;
    else if (m_ready) m_ovr = 1;
    else begin
      m_slot[m_idx] = b;
      if (m_idx == 4) begin m_ready = 1; m_idx = 5; end
      else m_idx++;
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic cpu_write(input logic [15:0] off, input logic [31:0] d);
    logic [7:0] t;
    if (!m_busy) begin
      case (off)
        16'h18: m_tx[0] = d;
        16'h1C: m_tx[1] = d;
        16'h20: m_tx[2] = d;
        16'h24: begin
          m_tx[3] = d;
          for (int i = 0; i < 4; i++) begin
            t = m_tx[i][7:0] + 8'h30;
            exp_q.push_back(t);
          end
          m_busy = 1;
        end
        default: ;
      endcase
    end
    if (off == 16'h24) begin m_ready = 0; m_idx = 0; m_ovr = 0; m_ferr = 0; end
    bus_wr(16'h0800 + off, d);
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    bit idle = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 600 && !idle; k++) begin
      bus_rd(16'h0828, d);
      if (d[0] == 1'b0) idle = 1;
    end
    check("tx_idle_timeout", 32'(idle), 32'd1);
    m_busy = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    logic [9:0] bits;
    bits = {good, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    model_rx(b, good);
  endtask

  task automatic rx_glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic check_rx_model(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      bus_rd(16'h0800 + 16'(4 * i), d);
      check($sformatf("%s_slot%0d", tag, i), d, {24'b0, m_slot[i]});
    end
    bus_rd(16'h0814, d);
    check({tag, "_ready"}, d, {31'b0, m_ready});
    bus_rd(16'h0828, d);
    check({tag, "_flags"}, d, {29'b0, m_ferr, m_ovr, m_busy});
  endtask

  // TX line decoder: samples each bit at its midpoint and checks against the queue
  initial begin
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 b[i] = tx;
      end
      repeat (CPB) @(posedge clk);
      #1 sb = tx;
      if (mon_en) begin
        check("tx_stop_bit", 32'(sb), 32'd1);
        check("tx_byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("tx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  frame [5];
    logic [31:0] r [4];
    int          n;

    frame = '{8'h31, 8'h32, 8'h2A, 8'h33, 8'h34};
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    #1 check("reset_tx", 32'(tx), 32'd1);
    bus_rd(16'h0814, d); check("reset_ready", d, 32'd0);
    bus_rd(16'h0828, d); check("reset_flags", d, 32'd0);
    bus_rd(16'h0800, d); check("reset_rx0", d, 32'd0);

    for (int i = 0; i < 5; i++) begin
      send_byte(frame[i], 1'b1);
      if (i == 3) begin bus_rd(16'h0814, d); check("ready_before_5th", d, 32'd0); end
      if (i == 4) begin bus_rd(16'h0814, d); check("ready_after_5th", d, 32'd1); end
    end
    check_rx_model("rx_frame");

    send_byte(8'h35, 1'b1);
    check_rx_model("rx_overrun");

    cpu_write(16'h24, 32'd0);
    check_rx_model("rearm");
    wait_idle();

    // launch timing and busy length
    cpu_write(16'h18, 32'd1);
    cpu_write(16'h1C, 32'd2);
    cpu_write(16'h20, 32'd3);
    cpu_write(16'h24, 32'd4);
    addr = 16'h0828;
    #1;
    check("busy_at_write_edge", {31'b0, rdata[0]}, 32'd0);
    check("tx_high_at_write_edge", 32'(tx), 32'd1);
    @(negedge clk);
    #1 check("tx_low_after_write", 32'(tx), 32'd0);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (rdata[0]) n++;
      else break;
      @(negedge clk);
      #1;
    end
    check("busy_cycles", 32'(n), 32'(40 * CPB));
    m_busy = 0;
    repeat (4) @(negedge clk);

    // writes while busy are dropped, rearm still happens
    for (int i = 0; i < 4; i++) r[i] = $urandom;
    cpu_write(16'h18, r[0]);
    cpu_write(16'h1C, r[1]);
    cpu_write(16'h20, r[2]);
    cpu_write(16'h24, r[3]);
    cpu_write(16'h18, 32'd9);
    bus_rd(16'h0818, d); check("tx0_write_dropped", d, m_tx[0]);
    cpu_write(16'h24, 32'h55);
    bus_rd(16'h0824, d); check("tx3_write_dropped", d, m_tx[3]);
    wait_idle();

    // random RX traffic, including bad stop bits and overruns
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    check_rx_model("rx_rand");

    // frame error keeps idx, glitch stores nothing
    cpu_write(16'h24, $urandom);
    wait_idle();
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    check_rx_model("rx_frame_err");
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    rx_glitch();
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    check_rx_model("rx_glitch");

    check("tx_queue_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a transmission
    cpu_write(16'h24, 32'd7);
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    #1 check("tx_after_reset", 32'(tx), 32'd1);
    rst = 1'b0;
    model_reset();
    bus_rd(16'h0828, d); check("flags_after_reset", d, 32'd0);
    bus_rd(16'h0824, d); check("tx3_after_reset", d, {m_tx[3]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral at CPU data address 0x0800. Receives a 5-byte ASCII frame over `rx` into word slots and raises a ready flag for the CPU to poll. Transmits four result digits over `tx` when the CPU writes the last result word. Serves the single-cycle core's data-memory port alongside DM, selected by address decode.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit, 8N1; minimum 4.
- `BASE`, 16'h0800: base address; block responds to `BASE`..`BASE+0x28`.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `addr` input 16: byte address from the core. Only word-aligned offsets decode.
- `we` input 1: store strobe, one cycle per store.
- `wdata` input 32: store data.
- `rdata` output 32: combinational read of the addressed register; 0 for undecoded offsets.
- `rx` input 1: serial in, idle high, asynchronous.
- `tx` output 1: serial out, idle high.

## Operation
- Register map, as offsets from `BASE`:
  - 0x00/0x04/0x08/0x0C/0x10: RX slots 0–4, read-only, `{24'b0, byte}`.
  - 0x14: READY, read-only, `{31'b0, ready}`.
  - 0x18/0x1C/0x20/0x24: TX slots 0–3, read/write, 32-bit.
  - 0x28: FLAGS, read-only, `{29'b0, frame_err, overrun, tx_busy}`.
- RX: 2-flop synchronizer on `rx`. States IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE.
  - A falling edge in IDLE enters START.
  - START re-samples at half-bit. If `rx` is high, it is a glitch: return to IDLE, nothing stored.
  - DATA and STOP sample at each full bit period after the start midpoint.
- On a good stop bit (1):
  - if ready=0, store the byte in slot `idx` and increment `idx`; when `idx` reaches 4 and stores, set ready=1 and hold `idx` at 5;
  - if ready=1, drop the byte and set overrun.
- Stop bit 0: discard the byte, set frame_err; `idx` is unchanged.
- A write to 0x24 rearms RX: ready←0, `idx`←0, overrun←0, frame_err←0. RX slot contents are retained until overwritten.
- TX: a write to 0x18–0x24 updates the slot only when tx_busy=0; otherwise the write is dropped.
- A write to 0x24 with tx_busy=0 also starts transmission of slots 0,1,2,3 in order. Each byte sent is `slot[7:0] + 8'h30` (mod 256). Frame: start 0, 8 data LSB-first, stop 1. The next start bit follows immediately after each stop bit.
- The rearm on a 0x24 write occurs regardless of tx_busy.
- Writes to any RX, READY or FLAGS offset are ignored.

## Timing
- Reset: `tx`=1, `rdata` reflects zeros. All slots 0, ready=0, `idx`=0, all flags 0, RX and TX FSMs IDLE.
- Reset mid-frame aborts both FSMs on the next edge; `tx` is high the cycle after reset.
- RX latency: slot write and ready set occur on the edge at the stop-bit sample (mid stop bit). Visible on `rdata` the following cycle.
- TX latency: `tx` goes low on the edge after the 0x24 write edge. tx_busy=1 from that same edge until the end of the 4th stop bit, which lasts `CLKS_PER_BIT` cycles. Total busy time is 40·`CLKS_PER_BIT` cycles.
- Simultaneous events:
  - a stop-bit store on the same edge as a 0x24 rearm: the rearm wins, the byte is discarded, and `idx`=0;
  - the RX path is fully independent of TX.

## Structure
- Shared package `uart_pkg`: register offset constants (`OFF_RX0`..`OFF_FLAGS`), RX/TX state enums, `ASCII_ZERO`=8'h30.
- One sub-module: `uart_tx_core` (byte-serial transmitter with start/busy/done handshake). The frame sequencer and RX stay in the top module.

## Test plan
- `CLKS_PER_BIT`=4, reset → `tx`=1; reads of 0x14 and 0x28 return 0; 0x00 reads 0.
- Serialize "12*34" (0x31,0x32,0x2A,0x33,0x34) on `rx` → slots read 0x31,0x32,0x2A,0x33,0x34. 0x14 reads 0 until the 5th stop-bit sample, then 1.
- With ready=1, send a 6th byte 0x35 → overrun=1, slot 0 still 0x31. Write 0x24 → ready=0, overrun=0, `idx`=0.
- Write 0x18=1, 0x1C=2, 0x20=3, 0x24=4 → `tx` emits 0x31,0x32,0x33,0x34. Each byte is 40 cycles at `CLKS_PER_BIT`=4; tx_busy is 1 for exactly 160 cycles.
- Write 0x18=9 while tx_busy=1 → write dropped; 0x18 still reads 1.
- Byte with stop bit 0 → frame_err=1, `idx` unchanged; 2-cycle low glitch on `rx` → nothing stored. Assert `rst` mid-TX → `tx`=1 next cycle, tx_busy=0.
